// File: rtl/arch_defs_pkg.sv
// Shared definitions for the program loader: bus widths, default sync marker
// and the loader FSM state encoding.
package arch_defs_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of idle cycles already elapsed, so the current
  // idle cycle is the TIMEOUT_CYCLES-th one when count == LAST.
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/prog_loader.sv
// Serial-link program loader: parses SYNC/ADDR/LEN/DATA/CHK frames, writes
// payload bytes to program memory and holds the CPU while a frame is in flight.
module prog_loader
  import arch_defs_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  loader_state_t         state;
  loader_state_t         state_next;
  logic                  accept;
  logic                  is_sync;
  logic                  last_byte;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] byte_cnt;
  logic [DATA_WIDTH-1:0] csum;
  logic [DATA_WIDTH-1:0] csum_next;

  assign rx_ready  = !reset;
  assign accept    = rx_valid && rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign csum_next = csum + rx_data;
  // LEN=0 loads 0 into byte_cnt, which then counts down through 255..1,
  // giving 256 data bytes without a wider counter.
  assign last_byte = (byte_cnt == DATA_WIDTH'(1));

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept || (state == ST_IDLE)),
    .enable (state != ST_IDLE),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      unique case (state)
        ST_IDLE:    if (is_sync) state_next = ST_ADDR_HI;
        ST_ADDR_HI: state_next = ST_ADDR_LO;
        ST_ADDR_LO: state_next = ST_LEN;
        ST_LEN:     state_next = ST_DATA;
        ST_DATA:    if (last_byte) state_next = ST_CHK;
        ST_CHK:     state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      ptr        <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (timeout_hit) begin
        cpu_hold   <= 1'b0;
        load_error <= 1'b1;
      end else if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (is_sync) begin
              cpu_hold   <= 1'b1;
              load_error <= 1'b0;
              csum       <= '0;
            end
          end
          ST_ADDR_HI: begin
            ptr[ADDR_WIDTH-1:DATA_WIDTH] <= rx_data;
            csum                         <= csum_next;
          end
          ST_ADDR_LO: begin
            ptr[DATA_WIDTH-1:0] <= rx_data;
            csum                <= csum_next;
          end
          ST_LEN: begin
            byte_cnt <= rx_data;
            csum     <= csum_next;
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= rx_data;
            ptr       <= ptr + ADDR_WIDTH'(1);
            byte_cnt  <= byte_cnt - DATA_WIDTH'(1);
            csum      <= csum_next;
          end
          ST_CHK: begin
            cpu_hold <= 1'b0;
            csum     <= csum_next;
            if (csum_next == '0) begin
              load_done <= 1'b1;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, address wrap, LEN=0,
// idle timeout and mid-frame reset, with writes captured into a log.
module tb_prog_loader;
  import arch_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [15:0] ea_q[$];
  logic [7:0]  ed_q[$];
  logic [7:0]  frm[$];

  always #5 clk = ~clk;

  prog_loader #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frm[i]) send(frm[i]);
    frm.delete();
  endtask

  task automatic expect_run(input logic [15:0] base, input logic [7:0] d0, input logic [7:0] step, input int n);
    logic [15:0] a;
    logic [7:0]  d;
    a = base;
    d = d0;
    for (int i = 0; i < n; i++) begin
      ea_q.push_back(a);
      ed_q.push_back(d);
      a = a + 16'd1;
      d = d + step;
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_wcount"}, 32'(wa_q.size()), 32'(ea_q.size()));
    n = (wa_q.size() < ea_q.size()) ? wa_q.size() : ea_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_waddr"}, 32'(wa_q[i]), 32'(ea_q[i]));
      check({tag, "_wdata"}, 32'(wd_q[i]), 32'(ed_q[i]));
    end
    wa_q.delete(); wd_q.delete(); ea_q.delete(); ed_q.delete();
  endtask

  task automatic std_good_frame(input string tag);
    int d0;
    d0 = done_cnt;
    frm = '{8'hA5, 8'hF0, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDC};
    send_frame();
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(load_error), 32'd0);
    tick();
    ea_q = '{16'hF000, 16'hF001, 16'hF002};
    ed_q = '{8'hAA, 8'hBB, 8'hCC};
    check_writes(tag);
    check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;

    // reset state
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    tick();
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0000);
    check("rst_wdata", 32'(mem_wdata), 32'h00);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("ready_up", 32'(rx_ready), 32'd1);
    check("idle_hold", 32'(cpu_hold), 32'd0);

    // good frame, step by step
    d0 = done_cnt;
    send(8'hA5);
    check("g1_hold_rise", 32'(cpu_hold), 32'd1);
    frm = '{8'hF0, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_frame();
    check("g1_hold_mid", 32'(cpu_hold), 32'd1);
    check("g1_done_early", 32'(load_done), 32'd0);
    send(8'hDC);
    check("g1_done", 32'(load_done), 32'd1);
    check("g1_hold_fall", 32'(cpu_hold), 32'd0);
    check("g1_err", 32'(load_error), 32'd0);
    tick();
    check("g1_done_pulse", 32'(load_done), 32'd0);
    ea_q = '{16'hF000, 16'hF001, 16'hF002};
    ed_q = '{8'hAA, 8'hBB, 8'hCC};
    check_writes("g1");
    check("g1_ndone", 32'(done_cnt - d0), 32'd1);

    // bad checksum, then a good frame clears the error
    d0 = done_cnt;
    frm = '{8'hA5, 8'hF0, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    send_frame();
    check("b_err", 32'(load_error), 32'd1);
    check("b_done", 32'(load_done), 32'd0);
    check("b_hold", 32'(cpu_hold), 32'd0);
    tick();
    check("b_err_sticky", 32'(load_error), 32'd1);
    ea_q = '{16'hF000, 16'hF001, 16'hF002};
    ed_q = '{8'hAA, 8'hBB, 8'hCC};
    check_writes("b");
    check("b_ndone", 32'(done_cnt - d0), 32'd0);
    send(8'hA5);
    check("b_err_clr", 32'(load_error), 32'd0);
    frm = '{8'hF0, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDC};
    send_frame();
    check("b2_done", 32'(load_done), 32'd1);
    tick();
    ea_q = '{16'hF000, 16'hF001, 16'hF002};
    ed_q = '{8'hAA, 8'hBB, 8'hCC};
    check_writes("b2");

    // leading noise and pointer wrap
    d0 = done_cnt;
    frm = '{8'h12, 8'h34};
    send_frame();
    check("n_hold", 32'(cpu_hold), 32'd0);
    check("n_state", 32'(dut.state), 32'(ST_IDLE));
    frm = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCD};
    send_frame();
    check("w_done", 32'(load_done), 32'd1);
    tick();
    ea_q = '{16'hFFFF, 16'h0000};
    ed_q = '{8'h11, 8'h22};
    check_writes("w");
    check("w_ndone", 32'(done_cnt - d0), 32'd1);

    // LEN=0 carries 256 bytes; 0x10 + sum(0..255)=0x90 mod 256, so CHK=0x70
    d0 = done_cnt;
    frm = '{8'hA5, 8'h10, 8'h00, 8'h00};
    send_frame();
    for (int i = 0; i < 256; i++) send(8'(i));
    check("l0_hold_before_chk", 32'(cpu_hold), 32'd1);
    send(8'h70);
    check("l0_done", 32'(load_done), 32'd1);
    check("l0_err", 32'(load_error), 32'd0);
    tick();
    expect_run(16'h1000, 8'h00, 8'h01, 256);
    check_writes("l0");
    check("l0_ndone", 32'(done_cnt - d0), 32'd1);

    // idle timeout after A5 F0
    d0 = done_cnt;
    frm = '{8'hA5, 8'hF0};
    send_frame();
    repeat (15) tick();
    check("t_hold_15", 32'(cpu_hold), 32'd1);
    check("t_err_15", 32'(load_error), 32'd0);
    tick();
    check("t_hold_16", 32'(cpu_hold), 32'd0);
    check("t_err_16", 32'(load_error), 32'd1);
    check("t_state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    check("t_ndone", 32'(done_cnt - d0), 32'd0);
    check_writes("t");
    std_good_frame("t2");

    // reset after two data bytes
    frm = '{8'hA5, 8'h20, 8'h00, 8'h05, 8'h11, 8'h22};
    send_frame();
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    #1;
    check("r_ready", 32'(rx_ready), 32'd0);
    tick();
    tick();
    check("r_we", 32'(mem_we), 32'd0);
    check("r_addr", 32'(mem_addr), 32'h0000);
    check("r_wdata", 32'(mem_wdata), 32'h00);
    check("r_hold", 32'(cpu_hold), 32'd0);
    check("r_done", 32'(load_done), 32'd0);
    check("r_err", 32'(load_error), 32'd0);
    check("r_state", 32'(dut.state), 32'(ST_IDLE));
    reset    = 1'b0;
    rx_valid = 1'b0;
    tick();
    tick();
    ea_q = '{16'h2000, 16'h2001};
    ed_q = '{8'h11, 8'h22};
    check_writes("r");
    d0 = done_cnt;
    frm = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h55, 8'h8A};
    send_frame();
    check("r2_done", 32'(load_done), 32'd1);
    tick();
    ea_q = '{16'h2000};
    ed_q = '{8'h55};
    check_writes("r2");
    check("r2_ndone", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
